// File: rtl/hpi_io_ctrl.sv
// CY7C67200 HPI bus sequencer: Avalon-MM slave to timed HPI cycles,
// plus OTG reset release and interrupt synchronisation.
module hpi_io_ctrl #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 2,
    parameter int unsigned RST_CYC     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic        irq,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic        otg_rst_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    input  logic        otg_int
);

    typedef enum logic [2:0] {
        S_RSTWAIT,
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE,
        S_RECOVER
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt;
    logic [15:0] r_rcnt;
    logic        r_dir;
    logic        w_dir;
    logic        w_accept;
    logic        w_bus;
    logic [15:0] r_rdata;
    logic [1:0]  r_addr;
    logic [15:0] r_dout;
    logic        r_cs_n;
    logic        r_rd_n;
    logic        r_wr_n;
    logic        r_oe;
    logic        r_rst_n;
    logic        r_int_s;
    logic        r_irq;

    always_comb begin
        w_next   = r_state;
        w_cnt    = r_cnt;
        w_accept = 1'b0;
        unique case (r_state)
            S_RSTWAIT: begin
                if (r_rcnt == 16'(RST_CYC))
                    w_next = S_IDLE;
            end
            S_IDLE: begin
                if (read || write) begin
                    w_accept = 1'b1;
                    w_next   = S_SETUP;
                    w_cnt    = 8'(SETUP_CYC - 1);
                end
            end
            S_SETUP: begin
                if (r_cnt == 8'd0) begin
                    w_next = S_STROBE;
                    w_cnt  = 8'(STROBE_CYC - 1);
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            S_STROBE: begin
                if (r_cnt == 8'd0) begin
                    w_next = S_HOLD;
                    w_cnt  = 8'(HOLD_CYC - 1);
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt == 8'd0)
                    w_next = S_DONE;
                else
                    w_cnt = r_cnt - 8'd1;
            end
            S_DONE: begin
                w_next = S_RECOVER;
                w_cnt  = 8'(RECOVER_CYC - 1);
            end
            S_RECOVER: begin
                if (r_cnt == 8'd0)
                    w_next = S_IDLE;
                else
                    w_cnt = r_cnt - 8'd1;
            end
            default: w_next = S_RSTWAIT;
        endcase
        // Direction is taken from the request on the accepting edge.
        w_dir = w_accept ? write : r_dir;
        w_bus = (w_next == S_SETUP) || (w_next == S_STROBE)
             || (w_next == S_HOLD);
    end

    // Pin registers are loaded from the next state so they switch
    // on the same edge as the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RSTWAIT;
            r_cnt   <= 8'd0;
            r_rcnt  <= 16'd0;
            r_dir   <= 1'b0;
            r_addr  <= 2'd0;
            r_dout  <= 16'd0;
            r_rdata <= 16'd0;
            r_cs_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_oe    <= 1'b0;
            r_rst_n <= 1'b0;
            r_int_s <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_dir   <= w_dir;
            if (r_state == S_RSTWAIT)
                r_rcnt <= r_rcnt + 16'd1;
            if (w_accept) begin
                r_addr <= address;
                r_dout <= writedata;
            end
            if (r_state == S_STROBE && r_cnt == 8'd0 && !r_dir)
                r_rdata <= otg_data_in;
            r_cs_n  <= !w_bus;
            r_rd_n  <= !(w_next == S_STROBE && !w_dir);
            r_wr_n  <= !(w_next == S_STROBE && w_dir);
            r_oe    <= w_bus && w_dir;
            r_rst_n <= (w_next != S_RSTWAIT);
            r_int_s <= otg_int;
            r_irq   <= r_int_s;
        end
    end

    assign waitrequest  = (read || write) && (r_state != S_DONE);
    assign readdata     = r_rdata;
    assign irq          = r_irq;
    assign otg_addr     = r_addr;
    assign otg_cs_n     = r_cs_n;
    assign otg_rd_n     = r_rd_n;
    assign otg_wr_n     = r_wr_n;
    assign otg_rst_n    = r_rst_n;
    assign otg_data_out = r_dout;
    assign otg_data_oe  = r_oe;

endmodule
